// File: rtl/jam_cost_table.sv
`default_nettype none
// ============================================================================
// Module      : jam_cost_table
// Description : 8x8 cost table for an assignment matcher. It loads row-major,
//               reads out combinationally, and tracks the sum of the row minima.
// Revision    : 1.0 - initial release
// ============================================================================
module jam_cost_table #(
    parameter int COST_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              load_valid,
    input  logic [COST_W-1:0] load_data,
    output logic              load_ready,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    output logic              table_ready,
    output logic              jam_rst,
    output logic [9:0]        LowerBound
);

    localparam int c_ENTRIES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [5:0]        r_cnt_q, w_cnt_d;
    logic [COST_W-1:0] r_row_min_q, w_row_min_d;
    logic [9:0]        r_lb_q, w_lb_d;
    logic              r_jam_rst_q, w_jam_rst_d;
    logic              w_we;
    logic [COST_W-1:0] w_min;
    logic [COST_W-1:0] r_mem [c_ENTRIES];

    // The first entry of each row seeds the running minimum.
    assign w_min = ((r_cnt_q[2:0] == 3'd0) || (load_data < r_row_min_q))
                   ? load_data : r_row_min_q;

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_row_min_d = r_row_min_q;
        w_lb_d      = r_lb_q;
        w_jam_rst_d = (r_state_q != READY);
        w_we        = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_state_d = LOAD;
                    w_cnt_d   = 6'd0;
                    w_lb_d    = 10'd0;
                end
            end
            LOAD: begin
                if (start) begin
                    w_cnt_d = 6'd0;
                    w_lb_d  = 10'd0;
                end else if (load_valid) begin
                    w_we        = 1'b1;
                    w_cnt_d     = r_cnt_q + 6'd1;
                    w_row_min_d = w_min;
                    if (r_cnt_q[2:0] == 3'd7) begin
                        w_lb_d = r_lb_q + 10'(w_min);
                    end
                    if (r_cnt_q == 6'd63) begin
                        w_state_d = READY;
                    end
                end
            end
            READY: begin
                if (start) begin
                    w_state_d   = LOAD;
                    w_cnt_d     = 6'd0;
                    w_lb_d      = 10'd0;
                    // Hold the matcher in reset on the same edge the table goes stale.
                    w_jam_rst_d = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q   <= IDLE;
            r_cnt_q     <= 6'd0;
            r_row_min_q <= '0;
            r_lb_q      <= 10'd0;
            r_jam_rst_q <= 1'b1;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_row_min_q <= w_row_min_d;
            r_lb_q      <= w_lb_d;
            r_jam_rst_q <= w_jam_rst_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[r_cnt_q] <= load_data;
        end
    end

    assign load_ready  = (r_state_q == LOAD);
    assign table_ready = (r_state_q == READY);
    assign jam_rst     = r_jam_rst_q;
    assign LowerBound  = r_lb_q;
    assign Cost        = table_ready ? r_mem[{W, J}] : '0;

endmodule
`default_nettype wire

// File: tb/tb_jam_cost_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_jam_cost_table
// Description : Directed self-checking bench for jam_cost_table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jam_cost_table;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       load_valid = 1'b0;
    logic [6:0] load_data = 7'd0;
    logic       load_ready;
    logic [2:0] W = 3'd0;
    logic [2:0] J = 3'd0;
    logic [6:0] Cost;
    logic       table_ready;
    logic       jam_rst;
    logic [9:0] LowerBound;

    int checks = 0;
    int errors = 0;

    logic [6:0] vals    [64];
    logic [6:0] exp_mem [64];
    logic [6:0] sb [$];

    jam_cost_table #(.COST_W(7)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .table_ready(table_ready),
        .jam_rst    (jam_rst),
        .LowerBound (LowerBound)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int exp_lb();
        int s = 0;
        for (int r = 0; r < 8; r++) begin
            int m = 127;
            for (int c = 0; c < 8; c++) begin
                if (int'(vals[r*8+c]) < m) m = int'(vals[r*8+c]);
            end
            s += m;
        end
        return s;
    endfunction

    task automatic start_pulse(input bit with_valid);
        start      = 1'b1;
        load_valid = with_valid;
        load_data  = 7'd77;
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
        #1;
        check("start_load_ready", load_ready, 1);
        check("start_table_ready", table_ready, 0);
        check("start_jam_rst", jam_rst, 1);
        check("start_lb_clear", LowerBound, 0);
    endtask

    // Streams vals[] in from cnt=0; optional bubbles on every other cycle.
    task automatic load_vals(input string tag, input bit toggle_valid);
        int i = 0;
        int cyc = 0;
        while (i < 64 && cyc < 200) begin
            load_valid = toggle_valid ? (cyc % 2 == 0) : 1'b1;
            load_data  = load_valid ? vals[i] : 7'h11;
            #1;
            check({tag, "_ready_during"}, load_ready, 1);
            check({tag, "_table_not_ready"}, table_ready, 0);
            if (load_valid) begin
                exp_mem[i] = vals[i];
                i++;
            end
            tick();
            cyc++;
        end
        load_valid = 1'b0;
        if (i < 64) check({tag, "_load_timeout"}, i, 64);
        check({tag, "_table_ready_rise"}, table_ready, 1);
        check({tag, "_load_ready_fall"}, load_ready, 0);
        check({tag, "_jam_rst_hold"}, jam_rst, 1);
        tick();
        check({tag, "_jam_rst_fall"}, jam_rst, 0);
        check({tag, "_lower_bound"}, LowerBound, exp_lb());
    endtask

    task automatic sweep(input string tag);
        for (int idx = 0; idx < 64; idx++) begin
            W = 3'(idx >> 3);
            J = 3'(idx & 7);
            sb.push_back(exp_mem[idx]);
            #1;
            check($sformatf("%s_cost_%0d", tag, idx), Cost, sb.pop_front());
            tick();
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check("rst_load_ready", load_ready, 0);
        check("rst_table_ready", table_ready, 0);
        check("rst_jam_rst", jam_rst, 1);
        check("rst_lower_bound", LowerBound, 0);
        check("rst_cost", Cost, 0);
        RST = 1'b0;
        tick();
        check("idle_load_ready", load_ready, 0);

        // Incrementing pattern, back-to-back.
        for (int i = 0; i < 64; i++) vals[i] = 7'(i % 128);
        start_pulse(1'b0);
        load_vals("inc", 1'b0);
        check("inc_lb_const", LowerBound, 224);
        load_valid = 1'b1;
        load_data  = 7'd0;
        repeat (3) begin
            tick();
            check("ready_ignores_valid", load_ready, 0);
        end
        load_valid = 1'b0;
        sweep("inc");

        // All maximum values with bubbles.
        for (int i = 0; i < 64; i++) vals[i] = 7'd127;
        start_pulse(1'b0);
        load_vals("max", 1'b1);
        check("max_lb_const", LowerBound, 1016);
        load_valid = 1'b1;
        load_data  = 7'h11;
        repeat (3) tick();
        load_valid = 1'b0;
        sweep("max");

        // Abort after 30 entries, then full reload.
        start_pulse(1'b0);
        for (int i = 0; i < 30; i++) begin
            load_valid = 1'b1;
            load_data  = 7'd99;
            tick();
        end
        check("abort_partial_lb", LowerBound, 297);
        start_pulse(1'b1);
        for (int i = 0; i < 64; i++) vals[i] = 7'd5;
        load_vals("five", 1'b0);
        check("five_lb_const", LowerBound, 40);
        sweep("five");

        // Asynchronous reset mid-load at cnt=10.
        start_pulse(1'b0);
        for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1;
            load_data  = 7'd9;
            tick();
        end
        check("pre_rst_lb", LowerBound, 9);
        load_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("arst_load_ready", load_ready, 0);
        check("arst_table_ready", table_ready, 0);
        check("arst_jam_rst", jam_rst, 1);
        check("arst_lower_bound", LowerBound, 0);
        check("arst_cost", Cost, 0);
        tick();
        RST = 1'b0;
        repeat (4) begin
            load_valid = 1'b1;
            load_data  = 7'd3;
            tick();
            check("post_rst_load_ready", load_ready, 0);
            check("post_rst_table_ready", table_ready, 0);
        end
        load_valid = 1'b0;
        for (int i = 0; i < 64; i++) vals[i] = 7'(i) ^ 7'h55;
        start_pulse(1'b0);
        load_vals("xor", 1'b0);
        sweep("xor");

        // Restart from READY with a coincident valid entry.
        start_pulse(1'b1);
        for (int i = 0; i < 64; i++) vals[i] = 7'((i * 3 + 17) % 128);
        load_vals("mul", 1'b0);
        sweep("mul");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
